// File: rtl/mem_resp.sv
// Single-port memory responder for the req/wr/rdy memory protocol.
// Accepts one read or write at a time, waits a programmable number of cycles,
// then commits the access to the on-chip RAM and returns a one-cycle rdy_m
// pulse. Word addresses beyond the RAM depth complete with err_m set.
module mem_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int RD_LAT     = 2,
  parameter int WR_LAT     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] addr_m,
  input  logic [63:0] dout_m,
  input  logic        req_m,
  input  logic        wr_m,
  output logic [63:0] din_m,
  output logic        rdy_m,
  output logic        err_m
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] RD_L = 4'(RD_LAT);
  localparam logic [3:0] WR_L = 4'(WR_LAT);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_RECOVER} state_t;

  state_t                  state_q;
  logic [3:0]              cnt_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic                    wr_q;
  logic                    oor_q;
  logic [63:0]             data_q;

  logic [63:0]             mem [DEPTH];

  // Decoded view of the incoming request
  logic                    req_oor;
  logic [3:0]              req_lat;
  logic [DEPTH_LOG2-1:0]   req_idx;

  // Access committed on this edge (the edge that enters RESP)
  logic                    com_en;
  logic                    com_wr;
  logic                    com_oor;
  logic [DEPTH_LOG2-1:0]   com_idx;
  logic [63:0]             com_data;

  assign req_oor = |addr_m[63:3+DEPTH_LOG2];
  assign req_lat = wr_m ? WR_L : RD_L;
  assign req_idx = addr_m[3 +: DEPTH_LOG2];

  // Select commit source: live request for zero latency, captured copy otherwise
  always_comb begin
    com_en   = 1'b0;
    com_wr   = wr_q;
    com_oor  = oor_q;
    com_idx  = idx_q;
    com_data = data_q;
    if (state_q == S_IDLE && req_m && req_lat == 4'd0) begin
      com_en   = 1'b1;
      com_wr   = wr_m;
      com_oor  = req_oor;
      com_idx  = req_idx;
      com_data = dout_m;
    end else if (state_q == S_WAIT && cnt_q == 4'd1) begin
      com_en   = 1'b1;
    end
  end

  // RAM write port; contents are never reset
  always_ff @(posedge clk) begin
    if (com_en && com_wr && !com_oor) begin
      mem[com_idx] <= com_data;
    end
  end

  // Request FSM with registered completion outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      oor_q   <= 1'b0;
      data_q  <= 64'd0;
      din_m   <= 64'd0;
      rdy_m   <= 1'b0;
      err_m   <= 1'b0;
    end else begin
      rdy_m <= 1'b0;
      if (com_en) begin
        rdy_m <= 1'b1;
        err_m <= com_oor;
        if (!com_wr) begin
          din_m <= com_oor ? 64'd0 : mem[com_idx];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_m) begin
            idx_q   <= req_idx;
            wr_q    <= wr_m;
            data_q  <= dout_m;
            oor_q   <= req_oor;
            cnt_q   <= req_lat;
            state_q <= (req_lat == 4'd0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= S_RESP;
          end
        end
        S_RESP:    state_q <= S_RECOVER;
        S_RECOVER: state_q <= S_IDLE;
        default:   state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_resp.sv
// Bench for mem_resp: three instances with different latencies share the
// request buses; each transaction pushes its expected completion into a
// per-instance queue that a negedge monitor pops when rdy_m appears.
module tb_mem_resp;

  localparam int RDL [3] = '{2, 0, 2};
  localparam int WRL [3] = '{1, 0, 4};

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] addr;
  logic [63:0] dout;
  logic        wr;
  logic        req_w [3];
  logic        rdy_w [3];
  logic        err_w [3];
  logic [63:0] din_w [3];

  always #5 clk = ~clk;

  mem_resp #(.DEPTH_LOG2(10), .RD_LAT(2), .WR_LAT(1)) u_a (
    .clk(clk), .reset(reset), .addr_m(addr), .dout_m(dout), .req_m(req_w[0]),
    .wr_m(wr), .din_m(din_w[0]), .rdy_m(rdy_w[0]), .err_m(err_w[0]));
  mem_resp #(.DEPTH_LOG2(10), .RD_LAT(0), .WR_LAT(0)) u_b (
    .clk(clk), .reset(reset), .addr_m(addr), .dout_m(dout), .req_m(req_w[1]),
    .wr_m(wr), .din_m(din_w[1]), .rdy_m(rdy_w[1]), .err_m(err_w[1]));
  mem_resp #(.DEPTH_LOG2(10), .RD_LAT(2), .WR_LAT(4)) u_c (
    .clk(clk), .reset(reset), .addr_m(addr), .dout_m(dout), .req_m(req_w[2]),
    .wr_m(wr), .din_m(din_w[2]), .rdy_m(rdy_w[2]), .err_m(err_w[2]));

  typedef struct {
    int          cyc;
    logic        err;
    logic [63:0] din;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  exp_t        q2[$];
  int          cyc = 0;
  int          total = 0;
  int          bad = 0;
  logic [63:0] mdl [int];
  logic [63:0] last_din [3];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference rules: 1024 words of 8 bytes; anything beyond is a range error
  function automatic bit is_oor(input logic [63:0] a);
    return (a / 64'd8) >= 64'd1024;
  endfunction

  function automatic int key(input int inst, input logic [63:0] a);
    return inst * 4096 + int'((a / 64'd8) % 64'd1024);
  endfunction

  task automatic push(input int inst, input exp_t e);
    case (inst)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Expected completion for a transaction accepted on the next edge
  function automatic exp_t predict(input int inst, input bit w, input logic [63:0] a,
                                   input logic [63:0] d, input int acc_cyc);
    exp_t e;
    int   lat;
    lat   = w ? WRL[inst] : RDL[inst];
    e.cyc = acc_cyc + lat;
    if (is_oor(a)) begin
      e.err = 1'b1;
      if (!w) last_din[inst] = 64'd0;
    end else begin
      e.err = 1'b0;
      if (w) mdl[key(inst, a)] = d;
      else   last_din[inst] = mdl.exists(key(inst, a)) ? mdl[key(inst, a)] : 64'hx;
    end
    e.din = last_din[inst];
    return e;
  endfunction

  task automatic txn(input int inst, input bit w, input logic [63:0] a, input logic [63:0] d);
    int n;
    @(negedge clk);
    addr = a;
    dout = d;
    wr   = w;
    req_w[inst] = 1'b1;
    push(inst, predict(inst, w, a, d, cyc + 1));
    n = 0;
    while (!rdy_w[inst] && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!rdy_w[inst]) begin
      total++;
      bad++;
      $display("FAIL timeout inst=%0d addr=%h got=no_rdy want=rdy", inst, a);
    end
    req_w[inst] = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  // Monitor: every rdy_m pulse must match the oldest expectation of its instance
  exp_t mon_e;
  bit   mon_got;
  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!reset && rdy_w[k]) begin
        mon_got = 1'b0;
        case (k)
          0: if (q0.size() > 0) begin mon_e = q0.pop_front(); mon_got = 1'b1; end
          1: if (q1.size() > 0) begin mon_e = q1.pop_front(); mon_got = 1'b1; end
          default: if (q2.size() > 0) begin mon_e = q2.pop_front(); mon_got = 1'b1; end
        endcase
        total++;
        if (!mon_got) begin
          bad++;
          $display("FAIL unexpected_rdy inst=%0d cyc=%0d got=rdy want=none", k, cyc);
        end else if (mon_e.cyc != cyc || mon_e.err !== err_w[k] || mon_e.din !== din_w[k]) begin
          bad++;
          $display("FAIL resp inst=%0d got cyc=%0d err=%0b din=%h want cyc=%0d err=%0b din=%h",
                   k, cyc, err_w[k], din_w[k], mon_e.cyc, mon_e.err, mon_e.din);
        end
      end
    end
  end

  logic [63:0] v0;
  logic [63:0] a;
  int          c;
  int          n;
  int          acc;
  exp_t        he;

  initial begin
    reset = 1'b1;
    addr  = 64'd0;
    dout  = 64'd0;
    wr    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_w[k]    = 1'b0;
      last_din[k] = 64'd0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("reset_rdy%0d", k), {63'd0, rdy_w[k]}, 64'd0);
      chk($sformatf("reset_err%0d", k), {63'd0, err_w[k]}, 64'd0);
      chk($sformatf("reset_din%0d", k), din_w[k], 64'd0);
    end
    reset = 1'b0;

    // Write then read back, default latencies
    txn(0, 1'b1, 64'h10, 64'hDEADBEEF_01234567);
    txn(0, 1'b0, 64'h10, 64'd0);
    // Misaligned write, aligned read of the same word
    txn(0, 1'b1, 64'h23, 64'hA5A5_0000_1234_5678);
    txn(0, 1'b0, 64'h20, 64'd0);
    // Out-of-range accesses must not alias word 0
    txn(0, 1'b1, 64'h0, 64'h0BAD_F00D_CAFE_0000);
    txn(0, 1'b1, 64'h2000, 64'hFFFF_FFFF_FFFF_FFFF);
    txn(0, 1'b0, 64'h2000, 64'd0);
    txn(0, 1'b0, 64'h0, 64'd0);

    // Request held high for 20 cycles: one completion every 5 cycles
    @(negedge clk);
    addr = 64'h10;
    wr   = 1'b0;
    req_w[0] = 1'b1;
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      he = predict(0, 1'b0, 64'h10, 64'd0, c + 1 + 5 * i);
      push(0, he);
    end
    repeat (20) @(negedge clk);
    req_w[0] = 1'b0;
    n = 0;
    while (q0.size() > 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);

    // Zero latency
    txn(1, 1'b1, 64'h18, 64'h1122_3344_5566_7788);
    txn(1, 1'b0, 64'h18, 64'd0);

    // Randomized traffic on a small pool of words
    for (int i = 0; i < 8; i++) begin
      txn(0, 1'b1, 64'h100 + 64'(8 * i), {$urandom(), $urandom()});
      txn(1, 1'b1, 64'h100 + 64'(8 * i), {$urandom(), $urandom()});
    end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(5) == 0)
        a = {$urandom(), $urandom()} | 64'h2000;
      else
        a = 64'h100 + 64'(8 * $urandom_range(7)) + 64'($urandom_range(7));
      txn($urandom_range(1), 1'($urandom_range(1)), a, {$urandom(), $urandom()});
    end

    // Reset in the middle of a long write
    v0 = 64'h0123_4567_89AB_CDEF;
    txn(2, 1'b1, 64'h8, v0);
    txn(2, 1'b0, 64'h8, 64'd0);
    @(negedge clk);
    addr = 64'h8;
    dout = 64'h55;
    wr   = 1'b1;
    req_w[2] = 1'b1;
    acc = cyc + 1;
    n = 0;
    while (cyc != acc + 2 && n < 10) begin
      @(negedge clk);
      n++;
    end
    reset = 1'b1;
    req_w[2] = 1'b0;
    #1;
    chk("midreset_rdy", {63'd0, rdy_w[2]}, 64'd0);
    chk("midreset_err", {63'd0, err_w[2]}, 64'd0);
    chk("midreset_din", din_w[2], 64'd0);
    for (int k = 0; k < 3; k++) last_din[k] = 64'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    txn(2, 1'b0, 64'h8, 64'd0);

    repeat (5) @(negedge clk);
    total++;
    if (q0.size() + q1.size() + q2.size() != 0) begin
      bad++;
      $display("FAIL pending got=%0d want=0", q0.size() + q1.size() + q2.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
